// File: rtl/sr16_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sr16_loader
//  Description : Sequencer that clears the sr16 divider-ratio shift register,
//                shifts a parallel word in MSB-first at a programmable bit
//                rate, then re-enables the register outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr16_loader #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             sys_clock,
    input  logic             sys_reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             abort,
    output logic             ser_data,
    output logic             ser_shift_en,
    output logic             ser_clear,
    output logic             ser_out_enable,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] committed_word
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [DIV_W-1:0] c_last_div = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] c_div_one  = DIV_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_SHIFT  = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift_buf;
    logic [WIDTH-1:0] r_load_word;
    logic [WIDTH-1:0] r_committed_word;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_load_ready;
    logic             r_ser_shift_en;
    logic             r_ser_clear;
    logic             r_ser_out_enable;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_strobe;

    assign w_accept = load_valid && r_load_ready && (r_state == S_IDLE);
    assign w_strobe = (r_div_cnt == c_last_div);

    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            r_state          <= S_IDLE;
            r_shift_buf      <= '0;
            r_load_word      <= '0;
            r_committed_word <= '0;
            r_bit_cnt        <= '0;
            r_div_cnt        <= '0;
            r_load_ready     <= 1'b0;
            r_ser_shift_en   <= 1'b0;
            r_ser_clear      <= 1'b0;
            r_ser_out_enable <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_load_ready   <= ~w_accept;
                    r_ser_clear    <= w_accept;
                    r_ser_shift_en <= 1'b0;
                    if (w_accept) begin
                        r_shift_buf      <= load_data;
                        r_load_word      <= load_data;
                        r_bit_cnt        <= '0;
                        r_div_cnt        <= '0;
                        r_ser_out_enable <= 1'b0;
                        r_busy           <= 1'b1;
                        r_state          <= S_CLEAR;
                    end
                end

                S_CLEAR, S_SHIFT: begin
                    // Abort leaves sr16 cleared and its outputs disabled.
                    if (abort) begin
                        r_state        <= S_IDLE;
                        r_ser_clear    <= 1'b1;
                        r_ser_shift_en <= 1'b0;
                        r_busy         <= 1'b0;
                        r_load_ready   <= 1'b1;
                    end else if (r_state == S_CLEAR) begin
                        r_ser_clear    <= 1'b0;
                        r_ser_shift_en <= (CLK_DIV == 1);
                        r_state        <= S_SHIFT;
                    end else if (w_strobe) begin
                        r_shift_buf <= {r_shift_buf[WIDTH-2:0], 1'b0};
                        r_bit_cnt   <= r_bit_cnt + c_cnt_one;
                        r_div_cnt   <= '0;
                        if (r_bit_cnt == c_last_bit) begin
                            r_state          <= S_COMMIT;
                            r_ser_shift_en   <= 1'b0;
                            r_done           <= 1'b1;
                            r_ser_out_enable <= 1'b1;
                            r_committed_word <= r_load_word;
                        end else begin
                            r_ser_shift_en <= (CLK_DIV == 1);
                        end
                    end else begin
                        // Strobe is registered, so it is raised one cycle ahead.
                        r_div_cnt      <= r_div_cnt + c_div_one;
                        r_ser_shift_en <= ((r_div_cnt + c_div_one) == c_last_div);
                    end
                end

                S_COMMIT: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_load_ready <= 1'b1;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign load_ready     = r_load_ready;
    assign ser_data       = r_shift_buf[WIDTH-1];
    assign ser_shift_en   = r_ser_shift_en;
    assign ser_clear      = r_ser_clear;
    assign ser_out_enable = r_ser_out_enable;
    assign busy           = r_busy;
    assign done           = r_done;
    assign committed_word = r_committed_word;

endmodule
`default_nettype wire

// File: tb/tb_sr16_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr16_loader
//  Description : Directed + random bench for sr16_loader (CLK_DIV 4 and 1),
//                with a timeline reference model and an sr16 register model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr16_loader;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        load_valid;
    logic [15:0] load_data;
    logic        abort;

    logic        d4_ready, d4_data, d4_shift, d4_clear, d4_oe, d4_busy, d4_done;
    logic [15:0] d4_comm;
    logic        d1_ready, d1_data, d1_shift, d1_clear, d1_oe, d1_busy, d1_done;
    logic [15:0] d1_comm;
    logic [15:0] sr4, sr1;

    int          n_checks;
    int          n_fail;
    logic [15:0] exp_comm [2];

    sr16_loader #(.WIDTH(16), .CLK_DIV(4)) dut4 (
        .sys_clock(clk), .sys_reset(rst),
        .load_valid(load_valid & ~sel), .load_ready(d4_ready), .load_data(load_data),
        .abort(abort & ~sel), .ser_data(d4_data), .ser_shift_en(d4_shift),
        .ser_clear(d4_clear), .ser_out_enable(d4_oe), .busy(d4_busy),
        .done(d4_done), .committed_word(d4_comm)
    );

    sr16_loader #(.WIDTH(16), .CLK_DIV(1)) dut1 (
        .sys_clock(clk), .sys_reset(rst),
        .load_valid(load_valid & sel), .load_ready(d1_ready), .load_data(load_data),
        .abort(abort & sel), .ser_data(d1_data), .ser_shift_en(d1_shift),
        .ser_clear(d1_clear), .ser_out_enable(d1_oe), .busy(d1_busy),
        .done(d1_done), .committed_word(d1_comm)
    );

    // Downstream sr16 registers; contents are not reset.
    always @(posedge clk) begin
        if (d4_clear)      sr4 <= 16'h0;
        else if (d4_shift) sr4 <= {sr4[14:0], d4_data};
        if (d1_clear)      sr1 <= 16'h0;
        else if (d1_shift) sr1 <= {sr1[14:0], d1_data};
    end

    wire        m_ready = sel ? d1_ready : d4_ready;
    wire        m_data  = sel ? d1_data  : d4_data;
    wire        m_shift = sel ? d1_shift : d4_shift;
    wire        m_clear = sel ? d1_clear : d4_clear;
    wire        m_oe    = sel ? d1_oe    : d4_oe;
    wire        m_busy  = sel ? d1_busy  : d4_busy;
    wire        m_done  = sel ? d1_done  : d4_done;
    wire [15:0] m_comm  = sel ? d1_comm  : d4_comm;
    wire [15:0] m_par   = sel ? (d1_oe ? sr1 : 16'h0) : (d4_oe ? sr4 : 16'h0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output vector {ready,busy,clear,shift,data,done,oe}; data only where meaningful.
    function automatic logic [6:0] obs_vec(input bit care);
        return {m_ready, m_busy, m_clear, m_shift, care ? m_data : 1'b0, m_done, m_oe};
    endfunction

    // Full load transaction, expectations derived from the timeline relative
    // to the accept edge: cycle 1 clear, bits held d cycles each with the strobe
    // in the last one, done in cycle 2+16*d.
    task automatic check_load(input logic [15:0] word, input int ab_strobe, input bit ab_commit,
                              input bit keep_valid, input logic [15:0] nxt, input bit ab_idle);
        int d, total, ab_k, wait_n, strobes, idx, k;
        bit aborted, care, sh;
        logic [6:0] ev;
        d       = sel ? 1 : 4;
        total   = 2 + 16 * d;
        ab_k    = (ab_strobe > 0) ? 1 + ab_strobe * d : -1;
        aborted = 1'b0;
        strobes = 0;
        load_data  = word;
        load_valid = 1'b1;
        abort      = ab_idle;
        wait_n = 0;
        while (!m_ready && wait_n < 200) begin
            @(negedge clk);
            wait_n++;
        end
        chk("accept_wait", 32'(wait_n < 200), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        if (keep_valid) load_data = nxt;
        else            load_valid = 1'b0;
        k = 1;
        while (k <= total && !aborted) begin
            if (k > 1) @(negedge clk);
            care = (k <= total - 1);
            idx  = (k < 2) ? 0 : (k - 2) / d;
            sh   = (k >= 2) && (k <= total - 1) && ((k - 1) % d == 0);
            ev   = {1'b0, 1'b1, k == 1, sh, care ? word[15 - idx] : 1'b0, k == total, k == total};
            chk($sformatf("load %h d%0d cyc%0d", word, d, k), 32'(obs_vec(care)), 32'(ev));
            strobes += int'(m_shift);
            if (k == ab_k) begin
                abort   = 1'b1;
                aborted = 1'b1;
            end
            if (ab_commit && k == total) abort = 1'b1;
            k++;
        end
        @(negedge clk);
        abort = 1'b0;
        if (aborted) begin
            chk("abort_idle", 32'(obs_vec(1'b0)), 32'(7'b1010000));
            chk("abort_comm", 32'(m_comm), 32'(exp_comm[sel]));
            @(negedge clk);
            chk("abort_after", 32'(obs_vec(1'b0)), 32'(7'b1000000));
        end else begin
            exp_comm[sel] = word;
            chk("post_idle", 32'(obs_vec(1'b0)), 32'(7'b1000001));
            chk("committed", 32'(m_comm), 32'(word));
            chk("sr16_out", 32'(m_par), 32'(word));
            chk("strobe_cnt", 32'(strobes), 32'd16);
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exp_comm[0] = 16'h0;
        exp_comm[1] = 16'h0;
        sel         = 1'b0;
        load_valid  = 1'b0;
        load_data   = 16'h0;
        abort       = 1'b0;
        rst         = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_vals", 32'(obs_vec(1'b1)), 32'd0);
        chk("reset_comm", 32'(m_comm), 32'd0);
        rst = 1'b0;
        #1 chk("ready_before_edge", 32'(m_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_edge", 32'(obs_vec(1'b1)), 32'(7'b1000000));

        check_load(16'hA5C3, 0, 1'b0, 1'b0, 16'h0, 1'b0);
        check_load(16'hFFFF, 0, 1'b0, 1'b1, 16'h0001, 1'b0);
        check_load(16'h0001, 0, 1'b0, 1'b0, 16'h0, 1'b0);
        check_load(16'h1234, 5, 1'b0, 1'b0, 16'h0, 1'b0);

        // Unaligned reset in the middle of a shift.
        load_data  = 16'h5A5A;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (20) @(negedge clk);
        #3 rst = 1'b1;
        #1 chk("async_reset", 32'(obs_vec(1'b1)), 32'd0);
        chk("async_reset_comm", 32'(m_comm), 32'd0);
        exp_comm[0] = 16'h0;
        exp_comm[1] = 16'h0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rel_ready_before", 32'(m_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready_after", 32'(obs_vec(1'b1)), 32'(7'b1000000));
        check_load(16'h8001, 0, 1'b0, 1'b0, 16'h0, 1'b0);

        sel = 1'b1;
        check_load(16'h00FF, 0, 1'b0, 1'b0, 16'h0, 1'b0);

        sel = 1'b0;
        check_load(16'h3C3C, 0, 1'b1, 1'b1, 16'hC33C, 1'b0);
        check_load(16'hC33C, 0, 1'b0, 1'b0, 16'h0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            sel = 1'($urandom_range(0, 1));
            check_load(16'($urandom),
                       ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : 0,
                       1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
